// File: rtl/apb3_mailbox_slave.sv
// ---------------------------------------------------------------------------
// apb3_mailbox_slave
//
// APB3 completer providing a bidirectional 32-bit mailbox between the CPU and
// fabric stream logic. The outbound FIFO is written by the CPU and drained by
// the fabric. The inbound FIFO is filled by the fabric and drained by the CPU.
// Each access phase carries WAIT_STATES wait cycles. Illegal accesses complete
// with PSLVERR and have no side effect.
//
// Register map (PADDR[3:2]):
//   0 DATA   : write pushes outbound, read pops inbound
//   1 STATUS : [0] out_full [1] out_empty [2] in_full [3] in_empty
//              [15:8] out_count [23:16] in_count (read-only)
//   2 CTRL   : [0] irq_en, [1] out_flush, [2] in_flush (flush bits self-clear)
//   3        : reserved, any access errors
//
// Optional feature macro: APB3_MAILBOX_IRQ_EN
//   defined   : CTRL[0] is writable; irq = registered (irq_en & !in_empty)
//   undefined : CTRL[0] reads 0; irq tied 0
//
// Ports:
//   PCLK, PRESETN         clock, asynchronous active-low reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA/PREADY/PSLVERR   APB3 slot
//   out_data/out_valid/out_ready   outbound stream (fabric consumes)
//   in_data/in_valid/in_ready      inbound stream (fabric produces)
//   irq                            interrupt to the CPU
// ---------------------------------------------------------------------------
module apb3_mailbox_slave #(
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [2:0]    WAIT_LOAD  = 3'(WAIT_STATES);

  // -------------------------------------------------------------------------
  // Wait-state FSM
  // -------------------------------------------------------------------------
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       setup_phase, access_phase, pready;

  assign setup_phase  = PSEL & ~PENABLE;
  assign access_phase = PSEL & PENABLE;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pready     = 1'b1;
    if (setup_phase) begin
      state_next = ST_WAIT;
      cnt_next   = WAIT_LOAD;
    end else if (access_phase) begin
      pready = (cnt_reg == 3'd0);
      if (cnt_reg != 3'd0) begin
        cnt_next = cnt_reg - 3'd1;
      end else begin
        state_next = ST_IDLE;
      end
    end else begin
      state_next = ST_IDLE;
    end
  end

  assign PREADY = pready;

  // -------------------------------------------------------------------------
  // Address decode and commit qualification
  // -------------------------------------------------------------------------
  logic [1:0] addr;
  logic       is_data, is_status, is_ctrl, is_rsvd;
  logic       commit, err_cond, ok, ctrl_wr;

  // Channel 0 = outbound (CPU -> fabric), channel 1 = inbound (fabric -> CPU).
  logic [1:0]         push, pop, flush, full, empty;
  logic [1:0][31:0]   wdata, head;
  logic [1:0][CW-1:0] count;
  logic               irq_en;

  assign addr      = PADDR[3:2];
  assign is_data   = (addr == 2'd0);
  assign is_status = (addr == 2'd1);
  assign is_ctrl   = (addr == 2'd2);
  assign is_rsvd   = (addr == 2'd3);

  // Gating with PRESETN keeps the bus outputs quiet while reset is held.
  assign commit = PRESETN & PSEL & PENABLE & pready;

  // Flags come from registered state, so a same-cycle fabric push/pop never
  // rescues a CPU access that would otherwise fail.
  assign err_cond = (is_data & PWRITE & full[0])
                  | (is_data & ~PWRITE & empty[1])
                  | (is_status & PWRITE)
                  | is_rsvd;

  assign ok      = commit & ~err_cond;
  assign PSLVERR = commit & err_cond;
  assign ctrl_wr = ok & is_ctrl & PWRITE;

  assign push[0]  = ok & is_data & PWRITE;
  assign pop[0]   = ~empty[0] & out_ready;
  assign push[1]  = in_valid & ~full[1];
  assign pop[1]   = ok & is_data & ~PWRITE;
  assign flush[0] = ctrl_wr & PWDATA[1];
  assign flush[1] = ctrl_wr & PWDATA[2];
  assign wdata[0] = PWDATA;
  assign wdata[1] = in_data;

  // -------------------------------------------------------------------------
  // FIFOs
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [31:0]   mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [CW-1:0] count_reg;

      // Flush has priority: any fabric push/pop on the same edge is dropped.
      always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (flush[gi]) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + AW'(1);
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      // Storage carries no reset; the pointers define what is valid.
      always_ff @(posedge PCLK) begin
        if (push[gi]) mem[wr_ptr_reg] <= wdata[gi];
      end

      assign head[gi]  = mem[rd_ptr_reg];
      assign count[gi] = count_reg;
      assign full[gi]  = (count_reg == FULL_COUNT);
      assign empty[gi] = (count_reg == '0);
    end
  endgenerate

  assign out_data  = head[0];
  assign out_valid = ~empty[0];
  assign in_ready  = ~full[1];

  // -------------------------------------------------------------------------
  // Interrupt
  // -------------------------------------------------------------------------
`ifdef APB3_MAILBOX_IRQ_EN
  logic irq_en_reg, irq_reg;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_reg <= PWDATA[0];
      irq_reg <= irq_en_reg & ~empty[1];
    end
  end

  assign irq_en = irq_en_reg;
  assign irq    = irq_reg;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Read data: only driven during a successful read commit
  // -------------------------------------------------------------------------
  logic [31:0] status_word, ctrl_word, rdata_sel;

  assign status_word = {8'h00, 8'(count[1]), 8'(count[0]), 4'h0,
                        empty[1], full[1], empty[0], full[0]};
  assign ctrl_word   = {31'd0, irq_en};

  always_comb begin
    rdata_sel = 32'd0;
    case (addr)
      2'd0:    rdata_sel = head[1];
      2'd1:    rdata_sel = status_word;
      2'd2:    rdata_sel = ctrl_word;
      default: rdata_sel = 32'd0;
    endcase
  end

  assign PRDATA = (ok & ~PWRITE) ? rdata_sel : 32'd0;

  // Only PADDR[3:2] is decoded and CTRL uses PWDATA[2:0].
  logic unused_bits;
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:3], PWDATA[0]};

endmodule

// File: tb/tb_apb3_mailbox_slave.sv
module tb_apb3_mailbox_slave;

  localparam int DEPTH = 8;
  localparam int WS    = 2;
`ifdef APB3_MAILBOX_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, irq;

  apb3_mailbox_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queues plus the irq enable bit.
  logic [31:0] out_q[$];
  logic [31:0] in_q[$];
  bit          irq_en_m = 1'b0;

  function automatic logic [31:0] exp_status();
    int oc = out_q.size();
    int ic = in_q.size();
    return {8'h00, 8'(ic), 8'(oc), 4'h0,
            (ic == 0), (ic == DEPTH), (oc == 0), (oc == DEPTH)};
  endfunction

  // One APB transfer. fab[0] raises out_ready and fab[1] raises in_valid
  // during the commit cycle only.
  task automatic apb(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                     input bit [1:0] fab, output logic [31:0] rd,
                     output logic err, output int waits);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = wd;
    @(negedge PCLK);
    PENABLE = 1'b1;
    waits = 0;
    #1;
    while (PREADY !== 1'b1) begin
      waits++;
      if (waits > 20) begin
        n_checks++; n_fail++;
        $display("FAIL apb_timeout addr=%h pready=%b required 1", a, PREADY);
        break;
      end
      @(negedge PCLK); #1;
    end
    rd  = PRDATA;
    err = PSLVERR;
    if (fab[0]) out_ready = 1'b1;
    if (fab[1]) in_valid  = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic cpu_data_write(input logic [31:0] d, input bit fab_pop);
    logic [31:0] rd; logic err; int waits;
    bit exp_err = (out_q.size() == DEPTH);
    bit do_pop  = fab_pop && (out_q.size() != 0);
    apb(32'h0, 1'b1, d, {1'b0, fab_pop}, rd, err, waits);
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL data_write_err d=%h got=%b required=%b", d, err, exp_err);
    end
    n_checks++;
    if (waits !== WS) begin
      n_fail++;
      $display("FAIL data_write_waits got=%0d required=%0d", waits, WS);
    end
    if (do_pop) void'(out_q.pop_front());
    if (!exp_err) out_q.push_back(d);
    $display("write DATA %h err=%b waits=%0d", d, err, waits);
  endtask

  task automatic cpu_data_read(input bit fab_push, input logic [31:0] fw);
    logic [31:0] rd; logic err; int waits;
    bit exp_err = (in_q.size() == 0);
    logic [31:0] exp_rd = exp_err ? 32'h0 : in_q[0];
    bit do_push = fab_push && (in_q.size() < DEPTH);
    in_data = fw;
    apb(32'h0, 1'b0, 32'h0, {fab_push, 1'b0}, rd, err, waits);
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL data_read_err got=%b required=%b", err, exp_err);
    end
    n_checks++;
    if (rd !== exp_rd) begin
      n_fail++;
      $display("FAIL data_read_value got=%h required=%h", rd, exp_rd);
    end
    if (!exp_err) void'(in_q.pop_front());
    if (do_push) in_q.push_back(fw);
    $display("read DATA %h err=%b waits=%0d", rd, err, waits);
  endtask

  task automatic cpu_ctrl_write(input logic [31:0] wd, input bit [1:0] fab);
    logic [31:0] rd; logic err; int waits;
    bit do_pop  = fab[0] && !wd[1] && (out_q.size() != 0);
    bit do_push = fab[1] && !wd[2] && (in_q.size() < DEPTH);
    apb(32'h8, 1'b1, wd, fab, rd, err, waits);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_write_err got=%b required=0", err);
    end
    if (do_pop) void'(out_q.pop_front());
    if (do_push) in_q.push_back(in_data);
    if (wd[1]) out_q.delete();
    if (wd[2]) in_q.delete();
    irq_en_m = IRQ_ON & wd[0];
    $display("write CTRL %h err=%b", wd, err);
  endtask

  task automatic check_reg(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd; logic err; int waits;
    apb(a, 1'b0, 32'h0, 2'b00, rd, err, waits);
    n_checks++;
    if (rd !== exp || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s got=%h err=%b required=%h err=0", tag, rd, err, exp);
    end
    $display("read %s %h err=%b", tag, rd, err);
  endtask

  task automatic fab_push_one(input logic [31:0] d);
    bit exp_rdy = (in_q.size() < DEPTH);
    @(negedge PCLK);
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready got=%b required=%b count=%0d", in_ready, exp_rdy, in_q.size());
    end
    in_data = d; in_valid = 1'b1;
    @(negedge PCLK);
    in_valid = 1'b0;
    if (exp_rdy) in_q.push_back(d);
    $display("fabric push %h accepted=%b", d, exp_rdy);
  endtask

  task automatic fab_pop_one();
    bit exp_vld = (out_q.size() != 0);
    @(negedge PCLK);
    n_checks++;
    if (out_valid !== exp_vld) begin
      n_fail++;
      $display("FAIL out_valid got=%b required=%b", out_valid, exp_vld);
    end
    if (exp_vld) begin
      n_checks++;
      if (out_data !== out_q[0]) begin
        n_fail++;
        $display("FAIL out_data got=%h required=%h", out_data, out_q[0]);
      end
    end
    out_ready = 1'b1;
    @(negedge PCLK);
    out_ready = 1'b0;
    if (exp_vld) void'(out_q.pop_front());
    $display("fabric pop valid=%b data=%h", exp_vld, out_data);
  endtask

  task automatic test_reset();
    PRESETN = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    n_checks++;
    if ({PRDATA, PREADY, PSLVERR, out_valid, in_ready, irq} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs got prdata=%h pready=%b pslverr=%b out_valid=%b in_ready=%b irq=%b required 0/1/0/0/1/0",
               PRDATA, PREADY, PSLVERR, out_valid, in_ready, irq);
    end
    PRESETN = 1'b1;
    check_reg(32'h4, 32'h0000_000A, "reset_status");
    check_reg(32'h8, 32'h0, "reset_ctrl");
  endtask

  task automatic test_wait_write();
    cpu_data_write(32'hDEADBEEF, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL first_out got valid=%b data=%h required 1 deadbeef", out_valid, out_data);
    end
    check_reg(32'h4, exp_status(), "status_one");
    fab_pop_one();
  endtask

  task automatic test_out_full();
    for (int i = 0; i < DEPTH + 1; i++) cpu_data_write($urandom, 1'b0);
    check_reg(32'h4, exp_status(), "status_out_full");
    for (int i = 0; i < DEPTH; i++) fab_pop_one();
    fab_pop_one();
  endtask

  task automatic test_in_read();
    cpu_data_read(1'b0, 32'h0);
    fab_push_one(32'h12345678);
    cpu_data_read(1'b0, 32'h0);
    check_reg(32'h4, exp_status(), "status_in_empty");
  endtask

  task automatic test_wrap_alternate();
    for (int i = 0; i < DEPTH + 1; i++) fab_push_one($urandom);
    check_reg(32'h4, exp_status(), "status_in_full");
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) cpu_data_read(1'b0, 32'h0);
      else fab_push_one($urandom);
      if (i % 5 == 4) check_reg(32'h4, exp_status(), "status_alt");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: cpu_data_write($urandom, 1'($urandom_range(0, 1)));
        1: cpu_data_read(1'($urandom_range(0, 1)), $urandom);
        2: fab_push_one($urandom);
        default: fab_pop_one();
      endcase
      if (i % 10 == 9) check_reg(32'h4, exp_status(), "status_rand");
    end
  endtask

  task automatic test_flush_and_errors();
    logic [31:0] rd; logic err; int waits;
    cpu_ctrl_write(32'h6, 2'b00);
    for (int i = 0; i < 5; i++) cpu_data_write($urandom, 1'b0);
    cpu_ctrl_write(32'h2, 2'b01);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL out_valid_after_flush got=%b required=0", out_valid);
    end
    check_reg(32'h4, exp_status(), "status_after_flush");
    check_reg(32'h8, 32'h0, "ctrl_readback");
    for (int i = 0; i < 3; i++) fab_push_one($urandom);
    in_data = 32'hA5A5_0001;
    cpu_ctrl_write(32'h4, 2'b10);
    check_reg(32'h4, exp_status(), "status_in_flush");
    apb(32'h4, 1'b1, 32'hFFFF_FFFF, 2'b00, rd, err, waits);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL status_write_err got=%b required=1", err);
    end
    apb(32'hC, 1'b0, 32'h0, 2'b00, rd, err, waits);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL rsvd_read got err=%b data=%h required 1 0", err, rd);
    end
    apb(32'hC, 1'b1, 32'h1234, 2'b00, rd, err, waits);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL rsvd_write_err got=%b required=1", err);
    end
    check_reg(32'h4, exp_status(), "status_after_errors");
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < DEPTH; i++) cpu_data_write($urandom, 1'b0);
    cpu_data_write(32'hBAD0_0BAD, 1'b1);
    check_reg(32'h4, exp_status(), "status_full_push_pop");
    cpu_ctrl_write(32'h6, 2'b00);
    cpu_data_read(1'b1, 32'hC0FF_EE00);
    check_reg(32'h4, exp_status(), "status_empty_read_push");
    cpu_ctrl_write(32'h6, 2'b00);
  endtask

  task automatic test_irq();
    cpu_ctrl_write(32'h5, 2'b00);
    fab_push_one($urandom);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_lag got=%b required=0", irq);
    end
    @(negedge PCLK);
    n_checks++;
    if (irq !== irq_en_m) begin
      n_fail++;
      $display("FAIL irq_set got=%b required=%b", irq, irq_en_m);
    end
    cpu_data_read(1'b0, 32'h0);
    n_checks++;
    if (irq !== irq_en_m) begin
      n_fail++;
      $display("FAIL irq_hold got=%b required=%b", irq, irq_en_m);
    end
    @(negedge PCLK);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear got=%b required=0", irq);
    end
    check_reg(32'h8, {31'd0, irq_en_m}, "ctrl_irq_en");
  endtask

  initial begin
    test_reset();
    test_wait_write();
    test_out_full();
    test_in_read();
    test_wrap_alternate();
    test_random();
    test_flush_and_errors();
    test_same_cycle();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
